// File: rtl/codec_cfg_sched.sv
// Audio codec configuration scheduler: plays the power-up register table and
// then runtime mute/volume updates as 24-bit words to an I2C bit engine.
`timescale 1ns/1ps
module codec_cfg_sched #(
  parameter int RETRY_MAX = 3,
  parameter int GAP_CYC   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        vol_req,
  input  logic [6:0]  vol_val,
  input  logic        mute_req,
  input  logic        mute_val,
  output logic        tx_valid,
  output logic [23:0] tx_word,
  input  logic        tx_ready,
  input  logic        tx_done,
  input  logic        tx_nack,
  output logic        busy,
  output logic        init_done,
  output logic        error,
  output logic        vol_ack,
  output logic        mute_ack
);

  localparam int             RW       = $clog2(RETRY_MAX + 2);
  localparam logic [7:0]     GAP_LAST = 8'(GAP_CYC - 1);
  localparam logic [RW-1:0]  RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_ISSUE, S_WAIT, S_GAP} state_t;
  typedef enum logic [1:0] {JOB_INIT, JOB_MUTE, JOB_VOL} job_t;

  function automatic logic [15:0] init_entry(input logic [2:0] idx);
    logic [15:0] e;
    case (idx)
      3'd0:    e = {7'h0F, 9'h000};
      3'd1:    e = {7'h06, 9'h000};
      3'd2:    e = {7'h02, 9'h179};
      3'd3:    e = {7'h04, 9'h012};
      3'd4:    e = {7'h05, 9'h000};
      3'd5:    e = {7'h07, 9'h042};
      3'd6:    e = {7'h08, 9'h000};
      3'd7:    e = {7'h09, 9'h001};
      default: e = {7'h00, 9'h000};
    endcase
    return e;
  endfunction

  function automatic logic [23:0] mk_word(input logic [15:0] reg_data);
    return {8'h34, reg_data};
  endfunction

  state_t         state_q, state_d;
  job_t           job_q, job_d;
  logic [2:0]     idx_q, idx_d;
  logic [RW-1:0]  retry_q, retry_d, retry_inc;
  logic [7:0]     gap_q, gap_d;
  logic           init_active_q, init_active_d;
  logic           retry_pend_q, retry_pend_d;
  logic           start_p_q, start_p_d;
  logic           mute_p_q, mute_p_d;
  logic           vol_p_q, vol_p_d;
  logic           mute_new_q, mute_new_d;
  logic           vol_new_q, vol_new_d;
  logic           mute_val_q, mute_val_d;
  logic [6:0]     vol_val_q, vol_val_d;
  logic           start_prev_q, mute_prev_q, vol_prev_q;
  logic           tx_valid_q, tx_valid_d;
  logic [23:0]    tx_word_q, tx_word_d;
  logic           busy_q, busy_d;
  logic           init_done_q, init_done_d;
  logic           error_q, error_d;
  logic           vol_ack_q, vol_ack_d;
  logic           mute_ack_q, mute_ack_d;
  logic           start_rise, mute_rise, vol_rise, work_avail;

  assign start_rise = start & ~start_prev_q;
  assign mute_rise  = mute_req & ~mute_prev_q;
  assign vol_rise   = vol_req & ~vol_prev_q;
  // Runtime updates wait in their pending flags until the codec is initialised.
  assign work_avail = init_active_q | start_p_q | (init_done_q & (mute_p_q | vol_p_q));

  assign tx_valid  = tx_valid_q;
  assign tx_word   = tx_word_q;
  assign busy      = busy_q;
  assign init_done = init_done_q;
  assign error     = error_q;
  assign vol_ack   = vol_ack_q;
  assign mute_ack  = mute_ack_q;

  // Next-state, request bookkeeping and output decode.
  always_comb begin
    state_d       = state_q;
    job_d         = job_q;
    idx_d         = idx_q;
    retry_d       = retry_q;
    retry_inc     = retry_q + {{(RW-1){1'b0}}, 1'b1};
    gap_d         = gap_q;
    init_active_d = init_active_q;
    retry_pend_d  = retry_pend_q;
    start_p_d     = start_p_q | start_rise;
    mute_p_d      = mute_p_q | mute_rise;
    vol_p_d       = vol_p_q | vol_rise;
    mute_new_d    = mute_new_q | mute_rise;
    vol_new_d     = vol_new_q | vol_rise;
    mute_val_d    = mute_rise ? mute_val : mute_val_q;
    vol_val_d     = vol_rise ? vol_val : vol_val_q;
    tx_word_d     = tx_word_q;
    init_done_d   = init_done_q;
    error_d       = error_q;
    vol_ack_d     = 1'b0;
    mute_ack_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (work_avail) state_d = S_SELECT;
        else            state_d = S_IDLE;
      end
      S_SELECT: begin
        retry_d = {RW{1'b0}};
        if (init_active_q) begin
          job_d     = JOB_INIT;
          tx_word_d = mk_word(init_entry(idx_q));
          state_d   = S_ISSUE;
        end else if (start_p_q) begin
          start_p_d     = start_rise;
          init_done_d   = 1'b0;
          error_d       = 1'b0;
          idx_d         = 3'd0;
          init_active_d = 1'b1;
          job_d         = JOB_INIT;
          tx_word_d     = mk_word(init_entry(3'd0));
          state_d       = S_ISSUE;
        end else if (init_done_q && mute_p_q) begin
          mute_new_d = mute_rise;
          job_d      = JOB_MUTE;
          tx_word_d  = mk_word({7'h05, 5'b00000, mute_val_q, 3'b000});
          state_d    = S_ISSUE;
        end else if (init_done_q && vol_p_q) begin
          vol_new_d = vol_rise;
          job_d     = JOB_VOL;
          tx_word_d = mk_word({7'h02, 1'b1, 1'b0, vol_val_q});
          state_d   = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (tx_ready) state_d = S_WAIT;
        else          state_d = S_ISSUE;
      end
      S_WAIT: begin
        if (tx_done) begin
          gap_d        = 8'd0;
          state_d      = S_GAP;
          retry_pend_d = 1'b0;
          // A start during init rewinds the table once the word in flight settles.
          if (init_active_q && start_p_q) begin
            start_p_d   = start_rise;
            idx_d       = 3'd0;
            retry_d     = {RW{1'b0}};
            init_done_d = 1'b0;
            error_d     = 1'b0;
          end else if (!tx_nack) begin
            retry_d = {RW{1'b0}};
            case (job_q)
              JOB_INIT: begin
                if (idx_q == 3'd7) begin
                  init_done_d   = 1'b1;
                  init_active_d = 1'b0;
                  idx_d         = 3'd0;
                end else begin
                  idx_d = idx_q + 3'd1;
                end
              end
              JOB_MUTE: begin
                mute_ack_d = 1'b1;
                mute_p_d   = mute_new_q | mute_rise;
              end
              JOB_VOL: begin
                vol_ack_d = 1'b1;
                vol_p_d   = vol_new_q | vol_rise;
              end
              default: idx_d = idx_q;
            endcase
          end else if (retry_inc <= RETRY_LIM) begin
            retry_d      = retry_inc;
            retry_pend_d = 1'b1;
          end else begin
            retry_d = {RW{1'b0}};
            error_d = 1'b1;
            case (job_q)
              JOB_INIT: init_active_d = 1'b0;
              JOB_MUTE: mute_p_d = mute_new_q | mute_rise;
              JOB_VOL:  vol_p_d  = vol_new_q | vol_rise;
              default:  init_active_d = 1'b0;
            endcase
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (retry_pend_q) begin
            retry_pend_d = 1'b0;
            state_d      = S_ISSUE;
          end else if (work_avail) begin
            state_d = S_SELECT;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_valid_d = (state_d == S_ISSUE);
    busy_d     = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      job_q         <= JOB_INIT;
      idx_q         <= 3'd0;
      retry_q       <= {RW{1'b0}};
      gap_q         <= 8'd0;
      init_active_q <= 1'b0;
      retry_pend_q  <= 1'b0;
      start_p_q     <= 1'b0;
      mute_p_q      <= 1'b0;
      vol_p_q       <= 1'b0;
      mute_new_q    <= 1'b0;
      vol_new_q     <= 1'b0;
      mute_val_q    <= 1'b0;
      vol_val_q     <= 7'd0;
      start_prev_q  <= 1'b0;
      mute_prev_q   <= 1'b0;
      vol_prev_q    <= 1'b0;
      tx_valid_q    <= 1'b0;
      tx_word_q     <= 24'd0;
      busy_q        <= 1'b0;
      init_done_q   <= 1'b0;
      error_q       <= 1'b0;
      vol_ack_q     <= 1'b0;
      mute_ack_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      job_q         <= job_d;
      idx_q         <= idx_d;
      retry_q       <= retry_d;
      gap_q         <= gap_d;
      init_active_q <= init_active_d;
      retry_pend_q  <= retry_pend_d;
      start_p_q     <= start_p_d;
      mute_p_q      <= mute_p_d;
      vol_p_q       <= vol_p_d;
      mute_new_q    <= mute_new_d;
      vol_new_q     <= vol_new_d;
      mute_val_q    <= mute_val_d;
      vol_val_q     <= vol_val_d;
      start_prev_q  <= start;
      mute_prev_q   <= mute_req;
      vol_prev_q    <= vol_req;
      tx_valid_q    <= tx_valid_d;
      tx_word_q     <= tx_word_d;
      busy_q        <= busy_d;
      init_done_q   <= init_done_d;
      error_q       <= error_d;
      vol_ack_q     <= vol_ack_d;
      mute_ack_q    <= mute_ack_d;
    end
  end

endmodule

// File: tb/tb_codec_cfg_sched.sv
// Scoreboard bench for codec_cfg_sched: a monitor logs every handoff, an
// engine model answers with tx_done/tx_nack, and each test checks the log.
`timescale 1ns/1ps
module tb_codec_cfg_sched;

  logic        clk = 1'b0;
  logic        reset, start, vol_req, mute_req, mute_val, tx_ready, tx_done, tx_nack;
  logic [6:0]  vol_val;
  logic        tx_valid, busy, init_done, error, vol_ack, mute_ack;
  logic [23:0] tx_word;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [23:0] got_w[0:511];
  int          got_t[0:511];
  int          n_got = 0;
  int          rd_ptr = 0;
  int          cyc = 0;
  int          vol_ack_cyc = 0, vol_ack_pulses = 0;
  int          mute_ack_cyc = 0, mute_ack_pulses = 0, mute_ack_t = 0;
  logic        vol_ack_prev = 1'b0, mute_ack_prev = 1'b0;

  logic [23:0] nack_word = 24'h0;
  int          nack_budget = 0;
  int          nack_used = 0;

  codec_cfg_sched #(.RETRY_MAX(3), .GAP_CYC(64)) dut (
    .clk(clk), .reset(reset), .start(start),
    .vol_req(vol_req), .vol_val(vol_val),
    .mute_req(mute_req), .mute_val(mute_val),
    .tx_valid(tx_valid), .tx_word(tx_word), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_nack(tx_nack),
    .busy(busy), .init_done(init_done), .error(error),
    .vol_ack(vol_ack), .mute_ack(mute_ack)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] init_word(input int i);
    case (i)
      0: return 24'h341E00;
      1: return 24'h340C00;
      2: return 24'h340579;
      3: return 24'h340812;
      4: return 24'h340A00;
      5: return 24'h340E42;
      6: return 24'h341000;
      7: return 24'h341201;
      default: return 24'h000000;
    endcase
  endfunction

  // Monitor: log transfers and ack pulses on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (tx_valid === 1'b1 && tx_ready === 1'b1 && n_got < 512) begin
      got_w[n_got] <= tx_word;
      got_t[n_got] <= cyc;
      n_got        <= n_got + 1;
    end
    vol_ack_prev  <= vol_ack;
    mute_ack_prev <= mute_ack;
    if (vol_ack === 1'b1) vol_ack_cyc <= vol_ack_cyc + 1;
    if (vol_ack === 1'b1 && vol_ack_prev !== 1'b1) vol_ack_pulses <= vol_ack_pulses + 1;
    if (mute_ack === 1'b1) begin
      mute_ack_cyc <= mute_ack_cyc + 1;
      mute_ack_t   <= cyc;
    end
    if (mute_ack === 1'b1 && mute_ack_prev !== 1'b1) mute_ack_pulses <= mute_ack_pulses + 1;
  end

  // Engine model: finish each transfer 3 cycles later, NACKing the chosen word.
  initial begin : engine
    bit nk;
    tx_done = 1'b0;
    tx_nack = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        nk = (tx_word === nack_word) && (nack_used < nack_budget);
        if (nk) nack_used++;
        repeat (3) @(posedge clk);
        #1;
        tx_done = 1'b1;
        tx_nack = nk;
        @(posedge clk);
        #1;
        tx_done = 1'b0;
        tx_nack = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_for_words(input int n, input int budget, output bit ok);
    int k = 0;
    while (n_got < rd_ptr + n && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (n_got >= rd_ptr + n);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic pop_word(output logic [23:0] w, output int t);
    w = got_w[rd_ptr];
    t = got_t[rd_ptr];
    rd_ptr++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_word, busy, init_done, error, vol_ack, mute_ack} !== 30'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {tx_valid, tx_word, busy, init_done, error, vol_ack, mute_ack});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_init();
    bit ok;
    logic [23:0] w, e;
    int t, tp;
    for (int i = 0; i < 8; i++) exp_q.push_back(init_word(i));
    pulse_start();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b expected 1", busy); end
    wait_for_words(8, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL init_timeout: got %0d words expected 8", n_got - rd_ptr); end
    tp = 0;
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL init_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        if (w !== e) begin errors++; $display("FAIL init_word[%0d]: got %h expected %h", i, w, e); end
        if (i > 0) begin
          checks++;
          if (t - tp <= 64) begin errors++; $display("FAIL init_gap[%0d]: got %0d cycles expected >64", i, t - tp); end
        end
        tp = t;
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || init_done !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL init_end: got busy=%b init_done=%b error=%b expected 0/1/0", busy, init_done, error);
    end
  endtask

  task automatic test_runtime();
    bit ok;
    logic [23:0] w, e;
    int t, tv, m0, mc0, v0, vc0;
    m0 = mute_ack_pulses; mc0 = mute_ack_cyc; v0 = vol_ack_pulses; vc0 = vol_ack_cyc;
    exp_q.push_back(24'h340A08);
    exp_q.push_back(24'h340560);
    vol_req = 1'b1; vol_val = 7'h60; mute_req = 1'b1; mute_val = 1'b1;
    tick();
    vol_req = 1'b0; vol_val = 7'h00; mute_req = 1'b0; mute_val = 1'b0;
    wait_for_words(2, 1000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL runtime_timeout: got %0d words expected 2", n_got - rd_ptr); end
    tv = 0;
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL runtime_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        tv = t;
        if (w !== e) begin errors++; $display("FAIL runtime_word[%0d]: got %h expected %h", i, w, e); end
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || mute_ack_pulses != m0 + 1 || mute_ack_cyc != mc0 + 1) begin
      errors++;
      $display("FAIL mute_ack: got %0d pulses %0d cycles expected 1/1", mute_ack_pulses - m0, mute_ack_cyc - mc0);
    end
    checks++;
    if (vol_ack_pulses != v0 + 1 || vol_ack_cyc != vc0 + 1) begin
      errors++;
      $display("FAIL vol_ack: got %0d pulses %0d cycles expected 1/1", vol_ack_pulses - v0, vol_ack_cyc - vc0);
    end
    checks++;
    if (mute_ack_t >= tv) begin
      errors++; $display("FAIL ack_order: got mute_ack at %0d vol word at %0d expected earlier", mute_ack_t, tv);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    logic [23:0] w, e;
    int t, k, v0;
    v0 = vol_ack_pulses;
    tx_ready = 1'b0;
    vol_req = 1'b1; vol_val = 7'h11;
    tick();
    vol_req = 1'b0;
    k = 0;
    while (tx_valid !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    checks++;
    if (tx_valid !== 1'b1) begin errors++; $display("FAIL stall_valid: got %b expected 1", tx_valid); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (tx_valid !== 1'b1 || tx_word !== 24'h340511) begin
        errors++; $display("FAIL stall_hold[%0d]: got valid=%b word=%h expected 1/340511", i, tx_valid, tx_word);
      end
    end
    tick();
    tx_ready = 1'b1;
    exp_q.push_back(24'h340511);
    wait_for_words(1, 100, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok) begin
      errors++; $display("FAIL stall_word: got none expected %h", e);
    end else begin
      pop_word(w, t);
      if (w !== e) begin errors++; $display("FAIL stall_word: got %h expected %h", w, e); end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || n_got != rd_ptr || vol_ack_pulses != v0 + 1) begin
      errors++;
      $display("FAIL stall_single: got %0d extra words %0d acks expected 0/1", n_got - rd_ptr, vol_ack_pulses - v0);
    end
  endtask

  task automatic test_retry();
    bit ok;
    logic [23:0] w, e;
    int t;
    nack_word = 24'h340812;
    nack_budget = nack_used + 4;
    for (int i = 0; i < 3; i++) exp_q.push_back(init_word(i));
    for (int i = 0; i < 4; i++) exp_q.push_back(24'h340812);
    pulse_start();
    wait_for_words(7, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL retry_timeout: got %0d words expected 7", n_got - rd_ptr); end
    for (int i = 0; i < 7; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL retry_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        if (w !== e) begin errors++; $display("FAIL retry_word[%0d]: got %h expected %h", i, w, e); end
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || error !== 1'b1 || init_done !== 1'b0) begin
      errors++; $display("FAIL retry_abort: got busy=%b error=%b init_done=%b expected 0/1/0", busy, error, init_done);
    end
    repeat (200) @(negedge clk);
    checks++;
    if (n_got != rd_ptr) begin errors++; $display("FAIL retry_quiet: got %0d extra words expected 0", n_got - rd_ptr); end
    for (int i = 0; i < 8; i++) exp_q.push_back(init_word(i));
    pulse_start();
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b0) begin errors++; $display("FAIL retry_clear: got error=%b expected 0", error); end
    wait_for_words(8, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL rerun_timeout: got %0d words expected 8", n_got - rd_ptr); end
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL rerun_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        if (w !== e) begin errors++; $display("FAIL rerun_word[%0d]: got %h expected %h", i, w, e); end
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || init_done !== 1'b1 || error !== 1'b0) begin
      errors++; $display("FAIL rerun_end: got init_done=%b error=%b expected 1/0", init_done, error);
    end
  endtask

  task automatic test_vol_before_init();
    bit ok;
    logic [23:0] w, e;
    int t, v0;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    v0 = vol_ack_pulses;
    vol_req = 1'b1; vol_val = 7'h05;
    tick();
    vol_req = 1'b0;
    repeat (100) @(negedge clk);
    checks++;
    if (n_got != rd_ptr || busy !== 1'b0) begin
      errors++; $display("FAIL early_vol: got %0d words busy=%b expected 0/0", n_got - rd_ptr, busy);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(init_word(i));
    exp_q.push_back(24'h340505);
    pulse_start();
    wait_for_words(9, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL early_timeout: got %0d words expected 9", n_got - rd_ptr); end
    for (int i = 0; i < 9; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL early_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        if (w !== e) begin errors++; $display("FAIL early_word[%0d]: got %h expected %h", i, w, e); end
      end
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || vol_ack_pulses != v0 + 1) begin
      errors++; $display("FAIL early_ack: got %0d acks expected 1", vol_ack_pulses - v0);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [23:0] w, e;
    int t;
    for (int i = 0; i < 5; i++) exp_q.push_back(init_word(i));
    pulse_start();
    wait_for_words(5, 3000, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL mid_timeout: got %0d words expected 5", n_got - rd_ptr); end
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if ({tx_valid, tx_word, busy, init_done, error, vol_ack, mute_ack} !== 30'h0) begin
      errors++;
      $display("FAIL mid_reset: got %h expected 0", {tx_valid, tx_word, busy, init_done, error, vol_ack, mute_ack});
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_ptr >= n_got) begin
        errors++; $display("FAIL mid_word[%0d]: got none expected %h", i, e);
      end else begin
        pop_word(w, t);
        if (w !== e) begin errors++; $display("FAIL mid_word[%0d]: got %h expected %h", i, w, e); end
      end
    end
    repeat (150) @(negedge clk);
    checks++;
    if (n_got != rd_ptr || busy !== 1'b0 || init_done !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_stray: got %0d words busy=%b init_done=%b error=%b expected 0/0/0/0",
               n_got - rd_ptr, busy, init_done, error);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; vol_req = 1'b0; vol_val = 7'h00;
    mute_req = 1'b0; mute_val = 1'b0; tx_ready = 1'b1;
    test_reset();
    test_init();
    test_runtime();
    test_ready_stall();
    test_retry();
    test_vol_before_init();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
